// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// MULT/DIV take WIDTH+1 busy cycles; MTHI/MTLO write in a single cycle.
module muldiv_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     srca_q, srca_d;
    logic                 is_div_q, is_div_d;
    logic                 div_zero_q, div_zero_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 sgn_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo, rem;

    // Issue-time operand conditioning: signed ops work on magnitudes.
    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & srcA[WIDTH-1];
        b_neg  = sgn_op & srcB[WIDTH-1];
        a_mag  = a_neg ? ('0 - srcA) : srcA;
        b_mag  = b_neg ? ('0 - srcB) : srcB;
    end

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = res_neg_q ? ('0 - acc_q) : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        srca_d     = srca_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d    = StRun;
                            cnt_d      = CntW'(WIDTH - 1);
                            is_div_d   = op[1];
                            srca_d     = srcA;
                            div_zero_d = op[1] & (srcB == '0);
                            res_neg_d  = a_neg ^ b_neg;
                            rem_neg_d  = a_neg;
                            if (op[1]) begin
                                acc_d  = {{WIDTH{1'b0}}, a_mag};
                                opnd_d = b_mag;
                            end else begin
                                acc_d  = {{WIDTH{1'b0}}, b_mag};
                                opnd_d = a_mag;
                            end
                        end
                        3'b100:  hi_d = srcA;
                        3'b101:  lo_d = srcA;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        hi_d = srca_q;
                        lo_d = '1;
                    end else begin
                        // Most-negative / -1 lands here naturally as lo = most-negative, hi = 0.
                        hi_d = rem_neg_q ? ('0 - rem) : rem;
                        lo_d = res_neg_q ? ('0 - quo) : quo;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            srca_q     <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= HILO_RST;
            lo_q       <= HILO_RST;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            srca_q     <= srca_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model compared every cycle,
// plus directed operations with literal expected results.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b0;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.WIDTH(W), .HILO_RST('0)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [2*W-1:0] model_result(input logic [2:0] o, input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        longint sa, sb;
        int     qa, qb;
        logic [2*W-1:0] r;
        r = '0;
        case (o)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = sa * sb;
            end
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: begin
                qa = $signed(a);
                qb = $signed(b);
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else r = {32'(qa % qb), 32'(qa / qb)};
            end
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle-level expectation: a countdown of remaining busy cycles and a pending result.
    int             m_left = 0;
    logic [W-1:0]   m_hi = '0, m_lo = '0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi   = m_pend[2*W-1:W];
                        m_lo   = m_pend[W-1:0];
                        m_done = 1'b1;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'd3) begin
                    m_pend = model_result(op, srcA, srcB);
                    m_left = W + 1;
                end else if (op == 3'd4) begin
                    m_hi = srcA;
                end else if (op == 3'd5) begin
                    m_lo = srcA;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("cyc_busy", 32'(busy), 32'(m_left > 0));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo);
        int nb;
        bit ok;
        issue(o, a, b);
        wait_done(nb, ok);
        check({name, "_done_seen"}, 32'(ok), 32'd1);
        check({name, "_busy_cycles"}, 32'(nb), 32'd33);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        @(negedge clock);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen;
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_by0_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // MTHI/MTLO preload, then abort a MULTU with an ignored start in between.
        issue(3'd4, 32'h1234, 32'h0);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'h1234);
        issue(3'd5, 32'h5678, 32'h0);
        check("mtlo_lo", lo, 32'h5678);
        issue(3'd1, 32'd3, 32'd4);
        repeat (2) @(negedge clock);
        start = 1'b1; op = 3'd3; srcA = 32'd99; srcB = 32'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'h5678);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            @(negedge clock);
        end
        check("flush_quiet", 32'(seen), 32'd0);

        start = 1'b1; op = 3'd4; srcA = 32'hDEAD; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush_mthi_hi", hi, 32'h1234);
        check("flush_mthi_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation.
        issue(3'd2, 32'd50, 32'd3);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        run_op("mult_after_rst", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, sitting beside the ALU in the EX stage of the pipelined core.
- Executes signed and unsigned MULT/DIV over WIDTH-bit operands, plus MTHI/MTLO register writes.
- Drives busy into the hazard unit, which stalls IF/ID while an operation is in flight or an MFHI/MFLO is waiting.
- Supports flush from branch resolution, which the fixed-latency ALU path cannot do.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4).
- HILO_RST, 0, reset value of hi and lo.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue request, sampled at the rising edge.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- srcA  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- srcB  input  WIDTH  multiplier / divisor.
- flush  input  1  abort the in-flight operation (EXMEM branch taken).
- busy  output  1  operation in flight; the hazard unit stalls on it.
- done  output  1  one-cycle pulse when hi/lo have just been updated by MULT/DIV.
- hi  output  WIDTH  HI register (high product half / remainder).
- lo  output  WIDTH  LO register (low product half / quotient).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, hi=lo=HILO_RST, busy=0, done=0, counter=0.
- Reset mid-operation aborts immediately; no partial write.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU at edge N latches operands and goes to RUN; busy=1 from after edge N.
  - Latch: sign flags (signed ops only) and magnitudes |srcA|, |srcB|.
  - Counter loads WIDTH-1.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, yielding a WIDTH-bit quotient and remainder.
  - When the counter reaches 0, go to FIX. The counter decrements; there is no wrap.
- FIX: one cycle, at edge N+WIDTH+1.
  - Apply sign correction.
  - Write hi/lo.
  - done=1 for exactly this one cycle after the edge; busy=0; return to IDLE.
  - Total busy = WIDTH+1 cycles (33 at WIDTH=32).
- Signed results:
  - MULT: negate the 2*WIDTH product when the operand signs differ.
  - DIV: quotient sign = XOR of the operand signs; remainder sign = dividend sign.
  - Overflow (most-negative / -1) gives lo = most-negative, hi = 0.
- Divide by zero (DIV or DIVU), detected at issue: still runs the full latency, then writes lo = all ones and hi = srcA as issued.
- MTHI/MTLO: when start=1 in IDLE, write hi or lo at that edge. No busy, no done, single cycle.
- start while busy: ignored. Operands, op and hi/lo are unaffected; the hazard unit must hold the instruction.
- flush=1 at an edge while in RUN or FIX: go to IDLE, keep hi/lo unchanged, done=0, busy=0 after that edge.
- flush together with start in IDLE: flush wins; the start (including MTHI/MTLO) is dropped.
- flush in IDLE without start: no effect.
- Op codes 110/111 with start: no effect.
- Outputs are registered: hi/lo change only at FIX, MTHI/MTLO, or reset.
- The result is visible in the cycle after done's edge, i.e. a consumer may read hi/lo while done=1.

Test Plan (WIDTH=32):
- MULT srcA=0xFFFFFFFD (-3), srcB=7 -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2; then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> after 33 cycles lo=0xFFFFFFFF, hi=5, done pulses once.
- Abort and ignored start:
  - Preload MTHI 0x1234 and MTLO 0x5678 (no busy); start MULTU 3x4; pulse start (DIVU) at cycle 4 -> ignored; pulse flush at cycle 10 -> busy drops next edge, no done, hi=0x1234, lo=0x5678.
  - Then flush+MTHI in the same cycle -> hi stays 0x1234.
- Start DIV 50/3, assert reset low at cycle 5 asynchronously (mid-clock) -> immediately hi=lo=0, busy=0, done=0; after release, MULT 2x3 completes normally with lo=6, hi=0.
